// File: rtl/iterative_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Trial subtracts use a 4-bit-group borrow-lookahead subtractor.
// Optional feature macro: DIVIDER_EARLY_OUT_EN (dividend < divisor finishes at accept).
module iterative_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned SW = WIDTH + 1;
   localparam int unsigned NG = (SW + 3) / 4;
   localparam int unsigned PW = NG * 4;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_d, rem_d;
   logic             dbz_d;
   logic             in_ready_d, out_valid_d;

   logic [SW-1:0]    t_c;
   logic [PW-1:0]    sa_c, sb_c, diff_c;
   logic             borrow_c;
   logic             unused_diff;

   // One 4-bit group of a - b - bin with lookahead borrows; returns {bout, diff}
   function automatic logic [4:0] grp_sub(input logic [3:0] a, input logic [3:0] b,
                                          input logic bin);
      logic [3:0] p, g, bw;
      logic       bout;
      p     = ~(a ^ b);
      g     = ~a & b;
      bw[0] = bin;
      bw[1] = g[0] | (p[0] & bin);
      bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
      bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
      bout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | ((&p) & bin);
      return {bout, (~p) ^ bw};
   endfunction

   // Trial value: partial remainder shifted left with the next dividend bit
   assign t_c  = {r_q, q_q[WIDTH-1]};
   assign sa_c = PW'(t_c);
   assign sb_c = PW'(dvs_q);

   // Group-serial borrow chain; zero padding groups just propagate the borrow
   always_comb begin : sub_chain
      logic       bin;
      logic [4:0] gr;
      bin    = 1'b0;
      gr     = '0;
      diff_c = '0;
      for (int g = 0; g < int'(NG); g++) begin
         gr                = grp_sub(sa_c[4*g +: 4], sb_c[4*g +: 4], bin);
         diff_c[4*g +: 4]  = gr[3:0];
         bin               = gr[4];
      end
      borrow_c = bin;
   end

   // Only the low WIDTH difference bits are kept as the new remainder
   assign unused_diff = ^diff_c[PW-1:WIDTH];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, datapath and next-output logic
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quo_d   = quotient;
      rem_d   = remainder;
      dbz_d   = div_by_zero;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               dvs_d = divisor;
               r_d   = '0;
               q_d   = dividend;
               cnt_d = CW'(WIDTH - 1);
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  state_d = DONE;
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end
`ifdef DIVIDER_EARLY_OUT_EN
               else if (dividend < divisor) begin
                  state_d = DONE;
                  quo_d   = '0;
                  rem_d   = dividend;
               end
`endif
               else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (!borrow_c) begin
               r_d = diff_c[WIDTH-1:0];
               q_d = WIDTH'({q_q, 1'b1});
            end else begin
               r_d = t_c[WIDTH-1:0];
               q_d = WIDTH'({q_q, 1'b0});
            end
            if (cnt_q == '0) begin
               state_d = DONE;
               quo_d   = q_d;
               rem_d   = r_d;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q         <= '0;
         q_q         <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         r_q         <= r_d;
         q_q         <= q_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         quotient    <= quo_d;
         remainder   <= rem_d;
         div_by_zero <= dbz_d;
         in_ready    <= in_ready_d;
         out_valid   <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider (WIDTH=8 main instance, WIDTH=16 secondary).
module tb_iterative_divider;

   localparam int unsigned W = 8;
`ifdef DIVIDER_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, div_by_zero;
   logic [7:0]  dividend, divisor, quotient, remainder;

   logic        in_valid16, in_ready16, out_valid16, out_ready16, dbz16;
   logic [15:0] dividend16, divisor16, quotient16, remainder16;

   int n_vec = 0;
   int n_err = 0;

   iterative_divider #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   iterative_divider #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .dividend(dividend16), .divisor(divisor16),
      .out_valid(out_valid16), .out_ready(out_ready16),
      .quotient(quotient16), .remainder(remainder16), .div_by_zero(dbz16)
   );

   always #5 clk = ~clk;

   // Reference model: {div_by_zero, quotient, remainder}
   function automatic logic [16:0] ref8(input logic [7:0] a, input logic [7:0] b);
      if (b == 8'd0) return {1'b1, 8'hFF, a};
      return {1'b0, 8'(a / b), 8'(a % b)};
   endfunction

   // Edges from the accept edge (inclusive) until out_valid is seen
   function automatic int exp_lat(input int unsigned a, input int unsigned b, input int unsigned w);
      if (b == 0 || (EARLY && a < b)) return 1;
      return int'(w) + 1;
   endfunction

   // Drives one operation through the 8-bit DUT and reports what it observed
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall, input bit poke,
                         output logic [7:0] q, output logic [7:0] r, output logic z,
                         output int lat, output bit hold_ok, output bit rel_ok, output bit tmo);
      int guard;
      tmo = 1'b0; hold_ok = 1'b1; rel_ok = 1'b0; lat = 0; q = '0; r = '0; z = 1'b0;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 64) begin @(negedge clk); guard++; end
      if (!in_ready) begin tmo = 1'b1; return; end
      in_valid = 1'b1; dividend = a; divisor = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
      lat = 1;
      while (!out_valid && lat < 64) begin
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      out_ready = 1'b0;
      if (!out_valid) begin tmo = 1'b1; return; end
      q = quotient; r = remainder; z = div_by_zero;
      for (int i = 0; i < stall; i++) begin
         if (poke) begin in_valid = 1'b1; dividend = 8'($urandom); divisor = 8'($urandom); end
         @(negedge clk);
         if (!out_valid || in_ready || quotient !== q || remainder !== r || div_by_zero !== z)
            hold_ok = 1'b0;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      rel_ok = (!out_valid && in_ready);
   endtask

   task automatic test_reset;
      #1;
      n_vec++;
      if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== 19'd0) begin
         n_err++;
         $display("FAIL reset_values: got rdy=%b vld=%b q=%0d r=%0d z=%b, want all zero",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_release_rdy0: got in_ready=%b, want 0", in_ready);
      end
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_release_rdy1: got in_ready=%b, want 1", in_ready);
      end
   endtask

   task automatic test_basic;
      logic [7:0] q, r; logic z; int lat; bit h, rl, t;
      run_op(8'd200, 8'd7, 0, 1'b0, q, r, z, lat, h, rl, t);
      n_vec++;
      if (t || {z, q, r} !== {1'b0, 8'd28, 8'd4}) begin
         n_err++; $display("FAIL basic_result: got q=%0d r=%0d z=%b tmo=%b, want q=28 r=4 z=0", q, r, z, t);
      end
      n_vec++;
      if (lat != 9) begin n_err++; $display("FAIL basic_latency: got %0d, want 9", lat); end
      n_vec++;
      if (!rl) begin n_err++; $display("FAIL basic_release: got 0, want 1"); end
   endtask

   task automatic test_boundaries;
      logic [7:0] ta[3] = '{8'd255, 8'd255, 8'd0};
      logic [7:0] tb[3] = '{8'd1, 8'd255, 8'd5};
      logic [7:0] tq[3] = '{8'd255, 8'd1, 8'd0};
      logic [7:0] q, r; logic z; int lat; bit h, rl, t;
      for (int i = 0; i < 3; i++) begin
         run_op(ta[i], tb[i], 1, 1'b0, q, r, z, lat, h, rl, t);
         n_vec++;
         if (t || {z, q, r} !== {1'b0, tq[i], 8'd0}) begin
            n_err++;
            $display("FAIL boundary_%0d/%0d: got q=%0d r=%0d z=%b, want q=%0d r=0 z=0",
                     ta[i], tb[i], q, r, z, tq[i]);
         end
         n_vec++;
         if (lat != exp_lat(ta[i], tb[i], W)) begin
            n_err++; $display("FAIL boundary_latency_%0d: got %0d, want %0d", i, lat, exp_lat(ta[i], tb[i], W));
         end
      end
   endtask

   task automatic test_div_by_zero;
      logic [7:0] q, r; logic z; int lat; bit h, rl, t;
      run_op(8'd77, 8'd0, 2, 1'b0, q, r, z, lat, h, rl, t);
      n_vec++;
      if (t || {z, q, r} !== {1'b1, 8'd255, 8'd77}) begin
         n_err++; $display("FAIL dbz_result: got q=%0d r=%0d z=%b, want q=255 r=77 z=1", q, r, z);
      end
      n_vec++;
      if (lat != 1) begin n_err++; $display("FAIL dbz_latency: got %0d, want 1", lat); end
      n_vec++;
      if (div_by_zero !== 1'b1) begin
         n_err++; $display("FAIL dbz_held_idle: got %b, want 1", div_by_zero);
      end
      run_op(8'd9, 8'd3, 0, 1'b0, q, r, z, lat, h, rl, t);
      n_vec++;
      if (t || {z, q, r} !== {1'b0, 8'd3, 8'd0}) begin
         n_err++; $display("FAIL dbz_cleared: got q=%0d r=%0d z=%b, want q=3 r=0 z=0", q, r, z);
      end
   endtask

   task automatic test_early_out;
      logic [7:0] q, r; logic z; int lat; bit h, rl, t;
      run_op(8'd3, 8'd10, 0, 1'b0, q, r, z, lat, h, rl, t);
      n_vec++;
      if (t || {z, q, r} !== {1'b0, 8'd0, 8'd3}) begin
         n_err++; $display("FAIL early_result: got q=%0d r=%0d z=%b, want q=0 r=3 z=0", q, r, z);
      end
      n_vec++;
      if (lat != exp_lat(3, 10, W)) begin
         n_err++; $display("FAIL early_latency: got %0d, want %0d", lat, exp_lat(3, 10, W));
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] q, r; logic z; int lat; bit h, rl, t;
      run_op(8'd50, 8'd6, 5, 1'b1, q, r, z, lat, h, rl, t);
      n_vec++;
      if (t || {z, q, r} !== {1'b0, 8'd8, 8'd2}) begin
         n_err++; $display("FAIL bp_result: got q=%0d r=%0d z=%b, want q=8 r=2 z=0", q, r, z);
      end
      n_vec++;
      if (!h) begin n_err++; $display("FAIL bp_hold: got unstable/ready during stall, want stable"); end
      n_vec++;
      if (!rl) begin n_err++; $display("FAIL bp_release: got 0, want in_ready=1 out_valid=0"); end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_no_accept: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid;
      bit seen;
      @(negedge clk);
      in_valid = 1'b1; dividend = 8'd100; divisor = 8'd7;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== 19'd0) begin
         n_err++;
         $display("FAIL midreset_values: got vld=%b rdy=%b q=%0d r=%0d z=%b, want all zero",
                  out_valid, in_ready, quotient, remainder, div_by_zero);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL midreset_ready: got %b, want 1", in_ready);
      end
      seen = 1'b0;
      repeat (15) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      n_vec++;
      if (seen) begin n_err++; $display("FAIL midreset_no_result: got out_valid=1, want 0"); end
   endtask

   task automatic test_width16;
      logic [15:0] a[4], b[4], eq[4], er[4];
      int lat;
      a[0] = 16'd65535; b[0] = 16'd3; eq[0] = 16'd21845; er[0] = 16'd0;
      for (int i = 1; i < 4; i++) begin
         a[i] = 16'($urandom);
         b[i] = 16'($urandom_range(1, (i == 1) ? 20 : 65535));
         eq[i] = a[i] / b[i]; er[i] = a[i] % b[i];
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         lat = 0;
         while (!in_ready16 && lat < 64) begin @(negedge clk); lat++; end
         in_valid16 = 1'b1; dividend16 = a[i]; divisor16 = b[i];
         @(posedge clk);
         @(negedge clk);
         in_valid16 = 1'b0;
         lat = 1;
         while (!out_valid16 && lat < 64) begin @(negedge clk); lat++; end
         n_vec++;
         if (!out_valid16 || {dbz16, quotient16, remainder16} !== {1'b0, eq[i], er[i]}) begin
            n_err++;
            $display("FAIL w16_%0d/%0d: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=0",
                     a[i], b[i], quotient16, remainder16, dbz16, eq[i], er[i]);
         end
         n_vec++;
         if (lat != exp_lat(a[i], b[i], 16)) begin
            n_err++; $display("FAIL w16_latency_%0d: got %0d, want %0d", i, lat, exp_lat(a[i], b[i], 16));
         end
         out_ready16 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready16 = 1'b0;
      end
   endtask

   task automatic test_random;
      logic [7:0] a, b, q, r; logic z; int lat; bit h, rl, t;
      logic [16:0] e;
      for (int n = 0; n < 2000; n++) begin
         a = 8'($urandom);
         case ($urandom_range(0, 3))
            0: b = 8'($urandom_range(0, 3));
            1: b = 8'($urandom_range(0, 15));
            default: b = 8'($urandom);
         endcase
         run_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), q, r, z, lat, h, rl, t);
         e = ref8(a, b);
         n_vec++;
         if (t || {z, q, r} !== e) begin
            n_err++;
            $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b",
                     a, b, q, r, z, e[15:8], e[7:0], e[16]);
         end
         n_vec++;
         if (lat != exp_lat(a, b, W)) begin
            n_err++; $display("FAIL rand_latency %0d/%0d: got %0d, want %0d", a, b, lat, exp_lat(a, b, W));
         end
         n_vec++;
         if (!h || !rl) begin
            n_err++; $display("FAIL rand_handshake %0d/%0d: got hold=%b release=%b, want 1 1", a, b, h, rl);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
      in_valid16 = 1'b0; out_ready16 = 1'b0; dividend16 = '0; divisor16 = '0;
      test_reset();
      test_basic();
      test_boundaries();
      test_div_by_zero();
      test_early_out();
      test_backpressure();
      test_reset_mid();
      test_width16();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
